// File: rtl/distribuidor_rr_1a4_if.sv
// Bus bundle for distribuidor_rr_1a4: one valid/ready input stream
// and four output channels (A..D), each with its own valid/ready pair.
interface distribuidor_rr_1a4_if #(
   parameter int ANCHO = 4
);
   logic [ANCHO-1:0] X;
   logic             valido_i;
   logic             listo_o;
   logic [ANCHO-1:0] A;
   logic [ANCHO-1:0] B;
   logic [ANCHO-1:0] C;
   logic [ANCHO-1:0] D;
   logic [3:0]       valido_o;
   logic [3:0]       listo_i;

   // Producer/consumer side: drives the input stream and the channel readies.
   modport master (
      output X, valido_i, listo_i,
      input  listo_o, A, B, C, D, valido_o
   );

   // Dispatcher side.
   modport slave (
      input  X, valido_i, listo_i,
      output listo_o, A, B, C, D, valido_o
   );
endinterface

// File: rtl/distribuidor_rr_1a4.sv
// distribuidor_rr_1a4: dispatches each accepted input word to one of four
// one-entry channel registers. Round-robin over free channels by default,
// or a fixed channel when modo_i=1. Reports the selector code of every
// dispatch (001=A .. 100=D, 000=idle) and counts accepted words.
module distribuidor_rr_1a4 #(
   parameter int ANCHO     = 4,
   parameter int ANCHO_CNT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   distribuidor_rr_1a4_if.slave bus,
   input  logic                 modo_i,
   input  logic [1:0]           canal_fijo_i,
   output logic [2:0]           Selector,
   output logic [ANCHO_CNT-1:0] contador_o
);

   logic [3:0]       vld_q;
   logic [ANCHO-1:0] dato_q [4];
   logic [1:0]       ptr;
   logic [3:0]       libre;
   logic [1:0]       cand_rr;
   logic             hallado;
   logic [1:0]       idx;
   logic [1:0]       cand;
   logic             listo;
   logic             acepta;

   // A channel can take a word if empty or if it drains on this same edge.
   assign libre = ~vld_q | bus.listo_i;

   // Round-robin search: first free channel starting at ptr, wrapping mod 4.
   always_comb begin
      cand_rr = ptr;
      hallado = 1'b0;
      idx     = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!hallado && libre[idx]) begin
            cand_rr = idx;
            hallado = 1'b1;
         end
      end
   end

   // Target channel and input readiness; valido_i never feeds listo_o.
   always_comb begin
      cand  = cand_rr;
      listo = hallado;
      if (modo_i) begin
         cand  = canal_fijo_i;
         listo = libre[canal_fijo_i];
      end
      if (!rst_n) listo = 1'b0;
   end

   assign acepta       = bus.valido_i & listo;
   assign bus.listo_o  = listo;
   assign bus.valido_o = vld_q;

   // Data is gated by valid, so the data registers themselves need no reset.
   assign bus.A = vld_q[0] ? dato_q[0] : '0;
   assign bus.B = vld_q[1] ? dato_q[1] : '0;
   assign bus.C = vld_q[2] ? dato_q[2] : '0;
   assign bus.D = vld_q[3] ? dato_q[3] : '0;

   // Control state: channel valids, selector pulse, counter and RR pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q      <= '0;
         Selector   <= 3'b000;
         contador_o <= '0;
         ptr        <= 2'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (acepta && (cand == 2'(k))) vld_q[k] <= 1'b1;
            else if (bus.listo_i[k])       vld_q[k] <= 1'b0;
         end
         if (acepta) begin
            Selector   <= {1'b0, cand} + 3'd1;
            contador_o <= contador_o + 1'b1;
            if (!modo_i) ptr <= cand + 2'd1;
         end else begin
            Selector <= 3'b000;
         end
      end
   end

   // Channel data capture; an occupied channel is only written when it drains.
   always_ff @(posedge clk) begin
      if (acepta) dato_q[cand] <= bus.X;
   end

endmodule
